// File: rtl/spook_cmd_pkg.sv
// Shared command/status encoding for the spook command path.
// Shared by the encoder and any decoder. Optional feature macro: SEED_LOAD_EN
// enables the LD_SEED operation.
package spook_cmd_pkg;

  localparam int WORD_W = 32;
  localparam int PAD_W  = 28;

  // Instruction opcodes, carried in word bits [31:28]
  localparam logic [3:0] OP_ENC       = 4'b0010;
  localparam logic [3:0] OP_DEC       = 4'b0011;
  localparam logic [3:0] OP_LDKEY     = 4'b0100;
  localparam logic [3:0] OP_LDKEY_ENC = 4'b1001;
  localparam logic [3:0] OP_LDKEY_DEC = 4'b1010;
  localparam logic [3:0] OP_LD_SEED   = 4'b1011;

  // Status codes, carried in word bits [31:28]
  localparam logic [3:0] ST_SUCCESS   = 4'b1110;
  localparam logic [3:0] ST_FAILURE   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_STAT = 2'd3
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] opcode;
  } decode_t;

  // Flags are {decrypt, key_update, key_only, seed_update}
  function automatic decode_t decode_flags(input logic [3:0] flags);
    decode_t d;
    d.legal  = 1'b1;
    d.opcode = OP_ENC;
    case (flags)
      4'b0000: d.opcode = OP_ENC;
      4'b1000: d.opcode = OP_DEC;
      4'b0110: d.opcode = OP_LDKEY;
      4'b0100: d.opcode = OP_LDKEY_ENC;
      4'b1100: d.opcode = OP_LDKEY_DEC;
`ifdef SEED_LOAD_EN
      4'b0001: d.opcode = OP_LD_SEED;
`endif
      default: begin
        d.legal  = 1'b0;
        d.opcode = 4'b0000;
      end
    endcase
    return d;
  endfunction

  // Operations that touch data produce a completion report from the core
  function automatic logic needs_done(input logic [3:0] op);
    return (op == OP_ENC) || (op == OP_DEC) ||
           (op == OP_LDKEY_ENC) || (op == OP_LDKEY_DEC);
  endfunction

  // Every emitted word carries a zero payload below the 4-bit code
  function automatic logic [WORD_W-1:0] make_word(input logic [3:0] code);
    return {code, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/instruction_encoder.sv
// Instruction encoder: turns an operation request into one instruction word,
// waits for the core's completion report when the operation has one, and
// emits a status word. One operation in flight at a time.
// Optional feature macro: SEED_LOAD_EN (handled in spook_cmd_pkg).
module instruction_encoder
  import spook_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_decrypt,
  input  logic        req_key_update,
  input  logic        req_key_only,
  input  logic        req_seed_update,
  output logic        req_err,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic        done_valid,
  input  logic        done_fail,
  output logic        done_ready,
  output logic [31:0] status_data,
  output logic        status_valid,
  input  logic        status_ready
);

  state_e      state_q;
  logic        req_ready_q, req_err_q, cmd_valid_q, done_ready_q, status_valid_q;
  logic        waits_q;
  logic [31:0] cmd_data_q, status_data_q;
  decode_t     dec;

  // Decode the request flags into an opcode plus legality
  always_comb begin
    dec = decode_flags({req_decrypt, req_key_update, req_key_only, req_seed_update});
  end

  // Control FSM; every handshake output is a register set on the transition
  // into the state that owns it, so none depends combinationally on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b0;
      req_err_q      <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_data_q     <= '0;
      done_ready_q   <= 1'b0;
      status_valid_q <= 1'b0;
      status_data_q  <= '0;
      waits_q        <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // req_ready is low on the first cycle out of reset; it is raised here
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            if (dec.legal) begin
              cmd_data_q  <= make_word(dec.opcode);
              waits_q     <= needs_done(dec.opcode);
              cmd_valid_q <= 1'b1;
              req_ready_q <= 1'b0;
              state_q     <= S_CMD;
            end else begin
              req_err_q <= 1'b1;
            end
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            if (waits_q) begin
              done_ready_q <= 1'b1;
              state_q      <= S_WAIT;
            end else begin
              req_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (done_valid) begin
            status_data_q  <= make_word(done_fail ? ST_FAILURE : ST_SUCCESS);
            status_valid_q <= 1'b1;
            done_ready_q   <= 1'b0;
            state_q        <= S_STAT;
          end
        end
        S_STAT: begin
          if (status_ready) begin
            status_valid_q <= 1'b0;
            req_ready_q    <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign req_err      = req_err_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_data     = cmd_data_q;
  assign done_ready   = done_ready_q;
  assign status_valid = status_valid_q;
  assign status_data  = status_data_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed, table-driven bench for instruction_encoder.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_decrypt = 1'b0, req_key_update = 1'b0, req_key_only = 1'b0, req_seed_update = 1'b0;
  logic        req_err;
  logic [31:0] cmd_data;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic        done_valid = 1'b0, done_fail = 1'b0, done_ready;
  logic [31:0] status_data;
  logic        status_valid, status_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  instruction_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_decrypt(req_decrypt), .req_key_update(req_key_update),
    .req_key_only(req_key_only), .req_seed_update(req_seed_update),
    .req_err(req_err),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done_valid(done_valid), .done_fail(done_fail), .done_ready(done_ready),
    .status_data(status_data), .status_valid(status_valid), .status_ready(status_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flags;
    logic        legal;
    logic [31:0] exp_cmd;
    logic        waits;
    int          hold;
    logic        fail;
    logic [31:0] exp_stat;
  } vec_t;

  vec_t vecs[10];

  // Advance one clock; outputs are then sampled and inputs driven 1ns past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    {req_decrypt, req_key_update, req_key_only, req_seed_update} = f;
  endtask

  task automatic run_op(input vec_t v);
    logic [31:0] held;
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    set_flags(v.flags);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    set_flags(4'b0000);
    if (!v.legal) begin
      chk("illegal_err_pulse", {31'b0, req_err}, 32'd1);
      chk("illegal_no_cmd", {31'b0, cmd_valid}, 32'd0);
      step();
      chk("illegal_err_one_cycle", {31'b0, req_err}, 32'd0);
      chk("illegal_no_cmd_after", {31'b0, cmd_valid}, 32'd0);
      chk("illegal_still_ready", {31'b0, req_ready}, 32'd1);
      return;
    end
    chk("cmd_valid_n1", {31'b0, cmd_valid}, 32'd1);
    chk("cmd_data", cmd_data, v.exp_cmd);
    chk("legal_no_err", {31'b0, req_err}, 32'd0);
    chk("busy_not_ready", {31'b0, req_ready}, 32'd0);
    held = cmd_data;
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk("cmd_hold_valid", {31'b0, cmd_valid}, 32'd1);
      chk("cmd_hold_stable", cmd_data, held);
    end
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("cmd_valid_drop", {31'b0, cmd_valid}, 32'd0);
    if (!v.waits) begin
      chk("nowait_back_idle", {31'b0, req_ready}, 32'd1);
      chk("nowait_no_done_ready", {31'b0, done_ready}, 32'd0);
      done_valid = 1'b1;
      step();
      done_valid = 1'b0;
      chk("nowait_done_ignored", {31'b0, status_valid}, 32'd0);
      chk("nowait_still_idle", {31'b0, req_ready}, 32'd1);
      return;
    end
    chk("wait_done_ready", {31'b0, done_ready}, 32'd1);
    chk("wait_no_status", {31'b0, status_valid}, 32'd0);
    done_valid = 1'b1;
    done_fail  = v.fail;
    step();
    done_valid = 1'b0;
    done_fail  = 1'b0;
    chk("status_valid_m1", {31'b0, status_valid}, 32'd1);
    chk("status_data", status_data, v.exp_stat);
    chk("done_ready_drop", {31'b0, done_ready}, 32'd0);
    step();
    chk("status_hold_valid", {31'b0, status_valid}, 32'd1);
    chk("status_hold_data", status_data, v.exp_stat);
    status_ready = 1'b1;
    step();
    status_ready = 1'b0;
    chk("status_drop", {31'b0, status_valid}, 32'd0);
    chk("back_idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    //          flags    legal  cmd           waits hold fail stat
    vecs[0] = '{4'b0000, 1'b1, 32'h20000000, 1'b1, 0, 1'b0, 32'hE0000000};
    vecs[1] = '{4'b1100, 1'b1, 32'hA0000000, 1'b1, 5, 1'b1, 32'hF0000000};
    vecs[2] = '{4'b0110, 1'b1, 32'h40000000, 1'b0, 1, 1'b0, 32'h0};
    vecs[3] = '{4'b1010, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0};
    vecs[4] = '{4'b0011, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0};
    vecs[5] = '{4'b0100, 1'b1, 32'h90000000, 1'b1, 2, 1'b0, 32'hE0000000};
    vecs[6] = '{4'b1000, 1'b1, 32'h30000000, 1'b1, 0, 1'b1, 32'hF0000000};
    vecs[7] = '{4'b1111, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0};
`ifdef SEED_LOAD_EN
    vecs[8] = '{4'b0001, 1'b1, 32'hB0000000, 1'b0, 0, 1'b0, 32'h0};
`else
    vecs[8] = '{4'b0001, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0};
`endif
    vecs[9] = '{4'b0010, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0};

    // Reset holds every output low, even with a request pending
    rst = 1'b1;
    req_valid = 1'b1;
    step();
    step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_req_err", {31'b0, req_err}, 32'd0);
    chk("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_cmd_data", cmd_data, 32'd0);
    chk("rst_done_ready", {31'b0, done_ready}, 32'd0);
    chk("rst_status_valid", {31'b0, status_valid}, 32'd0);
    chk("rst_status_data", status_data, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_no_cmd", {31'b0, cmd_valid}, 32'd0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Reset during WAIT abandons the operation; a late done is ignored
    set_flags(4'b0000);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("midrst_in_wait", {31'b0, done_ready}, 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_done_ready", {31'b0, done_ready}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("midrst_ready_after", {31'b0, req_ready}, 32'd1);
    done_valid = 1'b1;
    step();
    done_valid = 1'b0;
    chk("midrst_no_status", {31'b0, status_valid}, 32'd0);
    step();
    chk("midrst_no_status2", {31'b0, status_valid}, 32'd0);
    chk("midrst_no_cmd", {31'b0, cmd_valid}, 32'd0);
    run_op('{4'b1000, 1'b1, 32'h30000000, 1'b1, 0, 1'b0, 32'hE0000000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
